shifter_pipe: RTL and testbench
===============================

# shifter_pipe

Parametrised, pipelined barrel shifter that succeeds the single-cycle 16-bit SLL/SRA shifter in the datapath. It adds configurable width, configurable pipeline depth, two more modes (SRL, ROR), a registered zero flag, and valid/ready flow control. It sits between the execute-stage operand muxes and the ALU result mux. It is also reusable by wider datapaths.

## Interface

Parameters:
- WIDTH, 16, data width; power of two, 4..64
- PIPE, 2, number of register stages, 1..SHW where SHW = $clog2(WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when in_valid && in_ready
- in_data  in  WIDTH  operand
- in_amt  in  SHW  shift/rotate distance, 0..WIDTH-1
- in_mode  in  2  shift_mode_t: SLL=0, SRA=1, ROR=2, SRL=3
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  WIDTH  result
- out_zero  out  1  out_data == 0

## Operation

- Shift computation is decomposed into SHW levels; level k shifts/rotates by 2^k when amt[k]=1, else passes through.
- Level k is evaluated in stage floor(k*PIPE/SHW). Each stage register carries valid, partial data, mode, and amt.
- Modes:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the original bit WIDTH-1, propagated through each level.
  - ROR: bits leaving the LSB re-enter at the MSB.
- in_amt=0 gives out_data = in_data for all modes.
- out_zero is computed from the final-level data and registered together with out_data.
- Flow control is a standard stall pipeline:
  - A stage loads when it is empty or its contents are moving downstream this cycle.
  - in_ready = !v[0] || stage-0 advance.
  - The last stage advances when out_ready=1.
- While out_valid && !out_ready: out_data, out_zero, and all stage contents hold stable, with no bubbles created or lost.
- Results emerge strictly in acceptance order. No request is dropped or duplicated.
- Full pipeline with out_ready=1: accept and emit occur in the same cycle, sustaining 1 result/cycle.
- Full pipeline with out_ready=0: in_ready=0. Inputs are ignored until space frees.
- in_data/in_amt/in_mode are sampled only on acceptance; changes while in_ready=0 have no effect.

## Timing

- Latency: a request accepted at edge N gives out_valid=1 after edge N+PIPE-1 (i.e. PIPE register stages), absent backpressure.
- Throughput: 1 request/cycle.
- Capacity: PIPE requests in flight.
- in_ready is combinational from stage-valid bits and out_ready. There is no combinational path from in_* to out_*.
- Reset (async assert, sync release):
  - All stage valids = 0.
  - out_valid=0, out_data=0, out_zero=0.
  - in_ready=1 from the first cycle after release.
- Reset mid-operation discards all in-flight requests; none appear after release.
- Worst-case combinational depth per stage: ceil(SHW/PIPE) 2:1 mux levels.

## Structure

- Package shifter_pkg:
  - typedef enum logic [1:0] shift_mode_t {SLL, SRA, ROR, SRL}
  - function amt_width(WIDTH)
- Sub-module shifter_level (params WIDTH, DIST) is natural:
  - One mux level with inputs data, mode, sign bit, and enable; output is shifted data.
  - Instantiated SHW times via generate.
- The top level holds the stage registers and the handshake logic.

## Test plan

- WIDTH=16, PIPE=2, back-to-back with out_ready=1 (one output per cycle, outputs 2 cycles after acceptance):
  - SLL 16'h0001 by 15 -> 16'h8000
  - SRA 16'h8000 by 15 -> 16'hFFFF
  - SRL 16'h8000 by 4 -> 16'h0800
  - ROR 16'h8001 by 1 -> 16'hC000
- Amount 0 in every mode on 16'hA5A5 -> 16'hA5A5. Then SLL 16'h00FF by 8 -> 16'hFF00, out_zero=0. SRL 16'h0001 by 1 -> 16'h0000, out_zero=1.
- Backpressure:
  - Hold out_ready=0 and offer 4 requests: exactly 2 accepted, then in_ready=0.
  - The output holds steady for 3 cycles.
  - Release out_ready: all 4 results arrive in order with no duplicates.
- Random out_ready and in_valid (50% each), 10k requests: scoreboard against a reference model. Results must be exact and in order.
- Reset asserted asynchronously with 2 requests in flight: out_valid falls immediately. After release, in_ready=1 and no stale result appears.
- WIDTH=32, PIPE=5 and WIDTH=8, PIPE=1:
  - SRA 32'h80000000 by 31 -> 32'hFFFFFFFF
  - ROR 8'h01 by 7 -> 8'h02
  - Latency equals PIPE in each configuration.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
//   shift_mode_t : operation select (SLL, SRA, ROR, SRL)
//   amt_width    : bits needed for a shift distance of 0..width-1
//   lvl_stage    : register stage that evaluates mux level k
//   lvl_first    : level k is the first level evaluated in its stage
//   stage_last   : last mux level evaluated in stage s
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRA = 2'd1,
        ROR = 2'd2,
        SRL = 2'd3
    } shift_mode_t;

    function automatic int amt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Levels are spread evenly: level k lands in stage floor(k*pipe/shw).
    // With pipe <= shw every stage receives at least one level.
    function automatic int lvl_stage(input int k, input int pipe, input int shw);
        return (k * pipe) / shw;
    endfunction

    function automatic bit lvl_first(input int k, input int pipe, input int shw);
        if (k == 0)
            return 1'b1;
        return lvl_stage(k - 1, pipe, shw) != lvl_stage(k, pipe, shw);
    endfunction

    function automatic int stage_last(input int s, input int pipe, input int shw);
        int last;
        last = 0;
        for (int k = 0; k < shw; k++)
            if (lvl_stage(k, pipe, shw) == s)
                last = k;
        return last;
    endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Request/response bundle for shifter_pipe.
//   in_valid/in_ready   : request handshake, in_data/in_amt/in_mode payload
//   out_valid/out_ready : result handshake, out_data/out_zero payload
// master: requester side (drives in_*, out_ready)
// slave : shifter side (drives in_ready, out_*)
interface shifter_pipe_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
);
    localparam int SHW = amt_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    shift_mode_t      in_mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );

endinterface

// File: rtl/shifter_level.sv
// One barrel-shifter mux level: shifts/rotates data right (or left for SLL)
// by DIST when en is set, otherwise passes data through.
//   data : partial result from the previous level
//   mode : operation select
//   sign : original operand MSB, used as SRA fill
//   en   : amount bit for this level
//   q    : level output
module shifter_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  shift_mode_t      mode,
    input  logic             sign,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = data;
        if (en) begin
            case (mode)
                SLL:     q = data << DIST;
                SRL:     q = data >> DIST;
                SRA:     q = {{DIST{sign}}, data[WIDTH-1:DIST]};
                ROR:     q = {data[DIST-1:0], data[WIDTH-1:DIST]};
                default: q = data;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL) with valid/ready flow control.
// The SHW mux levels are distributed over PIPE register stages; each stage
// register holds valid, partial data, mode, amount and the operand sign.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : shifter_pipe_if.slave (request in, result out)
// Latency PIPE cycles, throughput 1/cycle, capacity PIPE requests.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2
) (
    input  logic         clk,
    input  logic         rst,
    shifter_pipe_if.slave bus
);

    localparam int SHW = amt_width(WIDTH);

    // Stage registers
    logic [PIPE-1:0]            v_q;
    logic [PIPE-1:0][WIDTH-1:0] d_q;
    logic [PIPE-1:0][SHW-1:0]   amt_q;
    logic [PIPE-1:0][1:0]       mode_q;
    logic [PIPE-1:0]            sign_q;
    logic                       z_q;

    // Per-stage source (input port for stage 0, previous register otherwise)
    logic [PIPE-1:0]            src_v;
    logic [PIPE-1:0][WIDTH-1:0] src_d;
    logic [PIPE-1:0][SHW-1:0]   src_amt;
    logic [PIPE-1:0][1:0]       src_mode;
    logic [PIPE-1:0]            src_sign;

    logic [PIPE-1:0][WIDTH-1:0] stg_res;
    logic [PIPE-1:0]            ld;

    for (genvar s = 0; s < PIPE; s++) begin : g_src
        if (s == 0) begin : g_in
            assign src_v[s]    = bus.in_valid;
            assign src_d[s]    = bus.in_data;
            assign src_amt[s]  = bus.in_amt;
            assign src_mode[s] = bus.in_mode;
            assign src_sign[s] = bus.in_data[WIDTH-1];
        end else begin : g_prev
            assign src_v[s]    = v_q[s-1];
            assign src_d[s]    = d_q[s-1];
            assign src_amt[s]  = amt_q[s-1];
            assign src_mode[s] = mode_q[s-1];
            assign src_sign[s] = sign_q[s-1];
        end
    end

    // Mux levels; a stage's first level starts from that stage's source,
    // later levels chain from the previous level inside the same stage.
    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        localparam int ST = lvl_stage(k, PIPE, SHW);
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] q;

        if (lvl_first(k, PIPE, SHW)) begin : g_head
            assign d = src_d[ST];
        end else begin : g_chain
            assign d = g_lvl[k-1].q;
        end

        shifter_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_lvl (
            .data (d),
            .mode (shift_mode_t'(src_mode[ST])),
            .sign (src_sign[ST]),
            .en   (src_amt[ST][k]),
            .q    (q)
        );
    end

    for (genvar s = 0; s < PIPE; s++) begin : g_res
        localparam int LAST = stage_last(s, PIPE, SHW);
        assign stg_res[s] = g_lvl[LAST].q;
    end

    // Stall chain from the output back: a stage loads when empty or when
    // the stage below is taking its contents this cycle.
    always_comb begin
        logic nxt;
        nxt = bus.out_ready;
        ld  = '0;
        for (int s = PIPE - 1; s >= 0; s--) begin
            ld[s] = !v_q[s] || nxt;
            nxt   = ld[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            d_q    <= '0;
            amt_q  <= '0;
            mode_q <= '0;
            sign_q <= '0;
            z_q    <= 1'b0;
        end else begin
            for (int s = 0; s < PIPE; s++) begin
                if (ld[s]) begin
                    v_q[s] <= src_v[s];
                    // Payload only moves with a valid entry; bubbles leave it alone.
                    if (src_v[s]) begin
                        d_q[s]    <= stg_res[s];
                        amt_q[s]  <= src_amt[s];
                        mode_q[s] <= src_mode[s];
                        sign_q[s] <= src_sign[s];
                    end
                end
            end
            if (ld[PIPE-1] && src_v[PIPE-1])
                z_q <= ~|stg_res[PIPE-1];
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[PIPE-1];
    assign bus.out_data  = d_q[PIPE-1];
    assign bus.out_zero  = z_q;

    // Amount bits of already-evaluated levels and the last stage's control
    // fields are carried along but never consumed.
    logic unused_ctl;
    assign unused_ctl = ^{amt_q, mode_q, sign_q, src_amt};

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed + scoreboarded bench for shifter_pipe in three configurations:
// 16/2 (main), 32/5 and 8/1 (latency and wide/narrow corner vectors).
module tb_shifter_pipe;
    import shifter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shifter_pipe_if #(.WIDTH(16)) bus ();
    shifter_pipe_if #(.WIDTH(32)) bus32 ();
    shifter_pipe_if #(.WIDTH(8))  bus8 ();

    shifter_pipe #(.WIDTH(16), .PIPE(2)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
    shifter_pipe #(.WIDTH(32), .PIPE(5)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    shifter_pipe #(.WIDTH(8),  .PIPE(1)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int n_cmp = 0;
    int n_bad = 0;

    localparam int NRAND = 10000;

    logic [15:0] sd [8];
    logic [3:0]  sa [8];
    shift_mode_t sm [8];
    logic [15:0] se [8];

    logic [15:0] q_exp [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref16(input logic [15:0] d, input logic [3:0] a, input shift_mode_t m);
        case (m)
            SLL:     return d << a;
            SRL:     return d >> a;
            SRA:     return 16'($signed(d) >>> a);
            default: return (d >> a) | (d << (5'd16 - {1'b0, a}));
        endcase
    endfunction

    task automatic idle16();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_amt   = '0;
        bus.in_mode  = SLL;
    endtask

    task automatic drv16(input logic [15:0] d, input logic [3:0] a, input shift_mode_t m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_mode  = m;
    endtask

    task automatic set_req(input int i, input logic [15:0] d, input logic [3:0] a,
                           input shift_mode_t m, input logic [15:0] e);
        sd[i] = d; sa[i] = a; sm[i] = m; se[i] = e;
    endtask

    // Back-to-back requests with out_ready=1; each result is due two
    // cycles after it is presented.
    task automatic run_stream(input int n, input string tag);
        for (int c = 0; c < n + 3; c++) begin
            @(posedge clk); #1;
            if (c < n) drv16(sd[c], sa[c], sm[c]); else idle16();
            @(negedge clk);
            if (c < n) chk({tag, "_rdy"}, 64'(bus.in_ready), 64'(1));
            if (c >= 2 && c < n + 2) begin
                chk({tag, "_vld"},  64'(bus.out_valid), 64'(1));
                chk({tag, "_data"}, 64'(bus.out_data),  64'(se[c-2]));
                chk({tag, "_zero"}, 64'(bus.out_zero),  64'(se[c-2] == 16'h0));
            end else begin
                chk({tag, "_idle"}, 64'(bus.out_valid), 64'(0));
            end
        end
    endtask

    task automatic t32(input string tag, input logic [31:0] d, input logic [4:0] a,
                       input shift_mode_t m, input logic [31:0] e);
        int lat;
        @(posedge clk); #1;
        bus32.in_valid = 1'b1; bus32.in_data = d; bus32.in_amt = a; bus32.in_mode = m;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(bus32.in_ready), 64'(1));
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 1;
        while (!bus32.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"},  64'(lat), 64'(5));
        chk({tag, "_data"}, 64'(bus32.out_data), 64'(e));
        chk({tag, "_zero"}, 64'(bus32.out_zero), 64'(e == 32'h0));
    endtask

    task automatic t8(input string tag, input logic [7:0] d, input logic [2:0] a,
                      input shift_mode_t m, input logic [7:0] e);
        int lat;
        @(posedge clk); #1;
        bus8.in_valid = 1'b1; bus8.in_data = d; bus8.in_amt = a; bus8.in_mode = m;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(bus8.in_ready), 64'(1));
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"},  64'(lat), 64'(1));
        chk({tag, "_data"}, 64'(bus8.out_data), 64'(e));
        chk({tag, "_zero"}, 64'(bus8.out_zero), 64'(e == 8'h0));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int n_out;
        int cyc;
        logic [15:0] exp;

        idle16();
        bus.out_ready   = 1'b1;
        bus32.in_valid  = 1'b0; bus32.in_data = '0; bus32.in_amt = '0; bus32.in_mode = SLL;
        bus32.out_ready = 1'b1;
        bus8.in_valid   = 1'b0; bus8.in_data = '0; bus8.in_amt = '0; bus8.in_mode = SLL;
        bus8.out_ready  = 1'b1;
        rst = 1'b1;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  64'(bus.out_valid), 64'(0));
        chk("rst_data", 64'(bus.out_data),  64'(0));
        chk("rst_zero", 64'(bus.out_zero),  64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rdy", 64'(bus.in_ready), 64'(1));

        // ---- back-to-back corner vectors ----
        set_req(0, 16'h0001, 4'd15, SLL, 16'h8000);
        set_req(1, 16'h8000, 4'd15, SRA, 16'hFFFF);
        set_req(2, 16'h8000, 4'd4,  SRL, 16'h0800);
        set_req(3, 16'h8001, 4'd1,  ROR, 16'hC000);
        run_stream(4, "b2b");

        // ---- zero amount, zero flag ----
        set_req(0, 16'hA5A5, 4'd0, SLL, 16'hA5A5);
        set_req(1, 16'hA5A5, 4'd0, SRA, 16'hA5A5);
        set_req(2, 16'hA5A5, 4'd0, SRL, 16'hA5A5);
        set_req(3, 16'hA5A5, 4'd0, ROR, 16'hA5A5);
        set_req(4, 16'h00FF, 4'd8, SLL, 16'hFF00);
        set_req(5, 16'h0001, 4'd1, SRL, 16'h0000);
        run_stream(6, "amt0");

        // ---- backpressure: two accepted, output frozen, ordered drain ----
        bus.out_ready = 1'b0;
        @(posedge clk); #1; drv16(16'h0003, 4'd2, SLL);
        @(negedge clk); chk("bp_rdy0", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1; drv16(16'h4000, 4'd3, SRA);
        @(negedge clk); chk("bp_rdy1", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1; drv16(16'h1234, 4'd4, ROR);
        @(negedge clk);
        chk("bp_full0", 64'(bus.in_ready),  64'(0));
        chk("bp_vld0",  64'(bus.out_valid), 64'(1));
        chk("bp_hold0", 64'(bus.out_data),  64'(16'h000C));
        @(posedge clk); #1; drv16(16'hDEAD, 4'd3, SLL);
        @(negedge clk);
        chk("bp_full1", 64'(bus.in_ready), 64'(0));
        chk("bp_hold1", 64'(bus.out_data), 64'(16'h000C));
        @(posedge clk); #1; drv16(16'h1234, 4'd4, ROR);
        @(negedge clk);
        chk("bp_full2", 64'(bus.in_ready),  64'(0));
        chk("bp_vld2",  64'(bus.out_valid), 64'(1));
        chk("bp_hold2", 64'(bus.out_data),  64'(16'h000C));
        @(posedge clk); #1; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy2", 64'(bus.in_ready), 64'(1));
        chk("bp_out0", 64'(bus.out_data), 64'(16'h000C));
        @(posedge clk); #1; drv16(16'hF00F, 4'd12, SRL);
        @(negedge clk);
        chk("bp_rdy3", 64'(bus.in_ready), 64'(1));
        chk("bp_out1", 64'(bus.out_data), 64'(16'h0800));
        @(posedge clk); #1; idle16();
        @(negedge clk);
        chk("bp_vld_o2", 64'(bus.out_valid), 64'(1));
        chk("bp_out2",   64'(bus.out_data),  64'(16'h4123));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_vld_o3", 64'(bus.out_valid), 64'(1));
        chk("bp_out3",   64'(bus.out_data),  64'(16'h000F));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drained", 64'(bus.out_valid), 64'(0));

        // ---- random valid/ready with scoreboard ----
        n_acc = 0; n_out = 0; cyc = 0;
        while (n_out < NRAND && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            bus.out_ready = 1'($urandom_range(0, 1));
            if (n_acc < NRAND && $urandom_range(0, 1) == 1)
                drv16(16'($urandom), 4'($urandom_range(0, 15)), shift_mode_t'(2'($urandom_range(0, 3))));
            else
                idle16();
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                chk("rnd_pending", 64'(q_exp.size() != 0), 64'(1));
                if (q_exp.size() != 0) begin
                    exp = q_exp.pop_front();
                    chk("rnd_data", 64'(bus.out_data), 64'(exp));
                    chk("rnd_zero", 64'(bus.out_zero), 64'(exp == 16'h0));
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q_exp.push_back(ref16(bus.in_data, bus.in_amt, bus.in_mode));
                n_acc++;
            end
        end
        chk("rnd_count", 64'(n_out), 64'(NRAND));
        @(posedge clk); #1;
        idle16();
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // ---- async reset with two requests in flight ----
        @(posedge clk); #1; drv16(16'h0F0F, 4'd4, SLL);
        @(posedge clk); #1; drv16(16'h00F0, 4'd4, SRL);
        @(posedge clk); #1; idle16();
        #1;
        chk("rf_vld",  64'(bus.out_valid), 64'(1));
        chk("rf_data", 64'(bus.out_data),  64'(16'hF0F0));
        #1; rst = 1'b1;
        #1;
        chk("rf_async_vld", 64'(bus.out_valid), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rf_rdy",  64'(bus.in_ready), 64'(1));
        chk("rf_data0", 64'(bus.out_data), 64'(0));
        chk("rf_zero0", 64'(bus.out_zero), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rf_no_stale", 64'(bus.out_valid), 64'(0));
        end

        // ---- other configurations ----
        t32("w32_sra", 32'h8000_0000, 5'd31, SRA, 32'hFFFF_FFFF);
        t32("w32_srl", 32'h8000_0000, 5'd31, SRL, 32'h0000_0001);
        t32("w32_ror", 32'h0000_0001, 5'd1,  ROR, 32'h8000_0000);
        t8("w8_ror", 8'h01, 3'd7, ROR, 8'h02);
        t8("w8_sra", 8'h80, 3'd3, SRA, 8'hF0);
        t8("w8_sll", 8'h81, 3'd1, SLL, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
